// File: rtl/icache_refill.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill
// Description : Instruction-cache miss engine. Accepts one fetch at a time,
//               looks it up in the cache, and on a miss reads a single word
//               from the memory bus, writes it into the cache and returns it.
//               Optional memory-wait watchdog: ICACHE_REFILL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] cache_addr,
  output logic [31:0] cache_wdata,
  output logic        cache_we,
  input  logic        cache_hit,
  input  logic [31:0] cache_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [15:0] miss_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_REQ    = 3'd2,
    S_WAIT   = 3'd3,
    S_FILL   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] req_addr;
  logic [31:0] fill_data;
  logic        timeout_abort;

`ifdef ICACHE_REFILL_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        resp_err_q;
  logic        at_limit;

  assign at_limit = (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
  // Forward progress on the limit edge beats the timeout.
  assign timeout_abort = at_limit &&
                         (((state == S_REQ)  && !mem_gnt) ||
                          ((state == S_WAIT) && !mem_rvalid));

  // Wait counter: restarts when REQ is entered, counts every REQ/WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if ((state == S_LOOKUP) && (state_next == S_REQ)) begin
      wait_cnt <= '0;
    end else if ((state == S_REQ) || (state == S_WAIT)) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Error flag travels with every response; only a timeout sets it.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_err_q <= 1'b0;
    end else begin
      resp_err_q <= timeout_abort;
    end
  end

  assign resp_err = resp_err_q;
`else
  logic unused_timeout;

  assign timeout_abort  = 1'b0;
  assign resp_err       = 1'b0;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  assign mem_addr    = req_addr;
  assign cache_wdata = fill_data;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the per-state handshake outputs.
  always_comb begin
    state_next  = state;
    fetch_ready = 1'b0;
    cache_addr  = req_addr;
    cache_we    = 1'b0;
    mem_req     = 1'b0;
    unique case (state)
      S_IDLE: begin
        fetch_ready = 1'b1;
        // The cache must see the incoming address on the accepting edge.
        cache_addr  = fetch_addr;
        if (fetch_valid) state_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        state_next = cache_hit ? S_IDLE : S_REQ;
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt)            state_next = S_WAIT;
        else if (timeout_abort) state_next = S_IDLE;
      end
      S_WAIT: begin
        if (mem_rvalid)         state_next = S_FILL;
        else if (timeout_abort) state_next = S_IDLE;
      end
      S_FILL: begin
        cache_we   = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Request/fill capture, registered response and the saturating miss counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr   <= '0;
      fill_data  <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      miss_count <= '0;
    end else begin
      resp_valid <= 1'b0;
      if ((state == S_IDLE) && fetch_valid) begin
        req_addr <= fetch_addr;
      end
      if ((state == S_WAIT) && mem_rvalid) begin
        fill_data <= mem_rdata;
      end
      if (state == S_LOOKUP) begin
        if (cache_hit) begin
          resp_valid <= 1'b1;
          resp_data  <= cache_rdata;
        end else if (miss_count != 16'hFFFF) begin
          miss_count <= miss_count + 16'd1;
        end
      end
      if (state == S_FILL) begin
        resp_valid <= 1'b1;
        resp_data  <= fill_data;
      end
      if (timeout_abort) begin
        resp_valid <= 1'b1;
        resp_data  <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_refill.sv
`default_nettype none
// Testbench for icache_refill: behavioural cache/memory environment, a
// queue-based scoreboard fed by the stimulus side and drained by a monitor.
module tb_icache_refill;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] cache_addr;
  logic [31:0] cache_wdata;
  logic        cache_we;
  logic        cache_hit;
  logic [31:0] cache_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [15:0] miss_count;

  icache_refill #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_we(cache_we),
    .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment cache: 32 word entries at addresses idx*4 (idx 0..31).
  logic [31:0] cvalid_bits;
  logic [31:0] cdata [32];
  logic        cache_flush;
  assign cache_hit   = cvalid_bits[cache_addr[6:2]] && (cache_addr[31:7] == '0) &&
                       (cache_addr[1:0] == 2'b00);
  assign cache_rdata = cdata[cache_addr[6:2]];
  always @(posedge clk) begin
    if (cache_flush) cvalid_bits <= '0;
    else if (cache_we) begin
      cvalid_bits[cache_addr[6:2]] <= 1'b1;
      cdata[cache_addr[6:2]]       <= cache_wdata;
    end
  end

  // Reference model state.
  logic [31:0] mem_words [32];
  logic [31:0] mc [int];
  int          model_misses = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp actual=resp_valid data=%h expected=no response", resp_data);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("resp_data", resp_data, e.data);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_ready();
    int to = 0;
    while (!fetch_ready && to < 60) begin
      @(negedge clk);
      to++;
    end
    chk("fetch_ready_timeout", {31'd0, fetch_ready}, 32'd1);
  endtask

  // Issue one fetch and play the memory side with the given delays.
  task automatic do_fetch(input int idx, input int gd, input int rd);
    logic [31:0] a;
    int n;
    a = 32'(idx) << 2;
    wait_ready();
    chk("miss_count", {16'd0, miss_count}, 32'(model_misses));
    fetch_valid = 1'b1;
    fetch_addr  = a;
    @(posedge clk);
    #1;
    n = cyc;
    fetch_valid = 1'b0;
    fetch_addr  = $urandom;
    if (mc.exists(idx)) begin
      sbq.push_back('{data: mc[idx], err: 1'b0, cyc: n + 1});
      @(negedge clk);
      chk("no_memreq_on_hit", {31'd0, mem_req}, 32'd0);
      mem_rvalid = 1'b0;
    end else begin
      model_misses++;
      sbq.push_back('{data: mem_words[idx], err: 1'b0, cyc: n + 4 + gd + rd});
      mc[idx] = mem_words[idx];
      @(negedge clk);
      chk("memreq_in_lookup", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      for (int k = 0; k < gd; k++) begin
        chk("memreq_stall", {31'd0, mem_req}, 32'd1);
        chk("memaddr_stall", mem_addr, a);
        chk("no_resp_stall", {31'd0, resp_valid}, 32'd0);
        mem_rvalid = 1'($urandom % 2);
        mem_rdata  = $urandom;
        @(negedge clk);
      end
      chk("memreq", {31'd0, mem_req}, 32'd1);
      chk("memaddr", mem_addr, a);
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b0;
      @(negedge clk);
      mem_gnt = 1'b0;
      chk("memreq_drop", {31'd0, mem_req}, 32'd0);
      for (int k = 0; k < rd; k++) @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = mem_words[idx];
      @(negedge clk);
      chk("fill_we", {31'd0, cache_we}, 32'd1);
      chk("fill_addr", cache_addr, a);
      chk("fill_wdata", cache_wdata, mem_words[idx]);
      mem_rvalid = 1'($urandom % 2);
      mem_rdata  = $urandom;
    end
  endtask

  function automatic int pick_uncached();
    for (int i = 0; i < 32; i++) if (!mc.exists(i)) return i;
    return -1;
  endfunction

  initial begin
    int idx;
    for (int i = 0; i < 32; i++) mem_words[i] = $urandom;
    mem_words[16] = 32'hDEAD_BEEF;
    reset = 1'b1; cache_flush = 1'b1;
    fetch_valid = 1'b0; fetch_addr = 32'h1234_5678;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_fetch_ready", {31'd0, fetch_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_cache_we", {31'd0, cache_we}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_cache_addr", cache_addr, 32'h1234_5678);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_cache_wdata", cache_wdata, 32'd0);
    chk("rst_miss_count", {16'd0, miss_count}, 32'd0);
    reset = 1'b0; cache_flush = 1'b0;

    // Cold miss at 0x40, minimum latency, then a hit on the same line.
    do_fetch(16, 0, 0);
    do_fetch(16, 0, 0);
    // Stalled bus.
    do_fetch(3, 10, 2);

    // Reset while waiting for read data; late grant/data must be ignored.
    idx = pick_uncached();
    wait_ready();
    fetch_valid = 1'b1; fetch_addr = 32'(idx) << 2;
    @(posedge clk); #1;
    fetch_valid = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_misses = 0;
    chk("rstwait_ready", {31'd0, fetch_ready}, 32'd1);
    chk("rstwait_miss_count", {16'd0, miss_count}, 32'd0);
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    repeat (4) begin
      chk("rstwait_no_we", {31'd0, cache_we}, 32'd0);
      chk("rstwait_no_resp", {31'd0, resp_valid}, 32'd0);
      chk("rstwait_no_req", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
    end

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      do_fetch(int'($urandom % 32), int'($urandom % 4), int'($urandom % 4));
    end

`ifdef ICACHE_REFILL_TIMEOUT_EN
    idx = pick_uncached();
    if (idx >= 0) begin
      int n;
      wait_ready();
      mem_rvalid = 1'b0;
      fetch_valid = 1'b1; fetch_addr = 32'(idx) << 2;
      @(posedge clk); #1;
      n = cyc;
      fetch_valid = 1'b0;
      model_misses++;
      sbq.push_back('{data: 32'd0, err: 1'b1, cyc: n + 9});
      repeat (14) begin
        @(negedge clk);
        chk("timeout_no_we", {31'd0, cache_we}, 32'd0);
      end
    end
`endif

    begin
      int to = 0;
      while (sbq.size() != 0 && to < 100) begin
        @(negedge clk);
        to++;
      end
    end
    while (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_resp actual=none expected=data %h at cycle %0d", e.data, e.cyc);
    end
    @(negedge clk);
    chk("final_miss_count", {16'd0, miss_count}, 32'(model_misses));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_refill.md
# icache_refill

Miss-handling engine that sits between the instruction-fetch stage and the `icache` array, on the opposite side of the cache's fill port. It takes one fetch request at a time, performs the cache lookup, and on a miss issues a single-word read to the memory bus. It then writes the returned word into the cache through the cache's `addr`/`data_in`/`write_enable` port and returns the instruction word to the fetch stage.

## Interface
- `TIMEOUT_CYCLES`, 255: memory-wait watchdog limit; used only when `ICACHE_REFILL_TIMEOUT_EN` is defined.
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_valid`  in  1  fetch request.
- `fetch_addr`  in  32  fetch address.
- `fetch_ready`  out  1  engine accepts a request; high only in IDLE.
- `resp_valid`  out  1  one-cycle response pulse (registered).
- `resp_data`  out  32  instruction word (registered).
- `resp_err`  out  1  response is a timeout error (registered).
- `cache_addr`  out  32  to cache `addr`.
- `cache_wdata`  out  32  to cache `data_in`.
- `cache_we`  out  1  to cache `write_enable`.
- `cache_hit`  in  1  from cache `hit`.
- `cache_rdata`  in  32  from cache `data_out`.
- `mem_req`  out  1  memory read request; held until granted.
- `mem_addr`  out  32  memory read address.
- `mem_gnt`  in  1  request accepted.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read data.
- `miss_count`  out  16  saturating miss counter.

## Operation
- **States:** IDLE, LOOKUP, REQ, WAIT, FILL.
- **IDLE**
  - `fetch_ready=1`; `cache_addr=fetch_addr` (combinational, so the cache samples the address on the accepting edge).
  - `fetch_valid=1` at an edge: latch `fetch_addr` into `req_addr` and go to LOOKUP.
- **LOOKUP**
  - `cache_addr=req_addr`; `cache_hit`/`cache_rdata` reflect `req_addr`.
  - Hit: register `resp_valid=1`, `resp_data=cache_rdata`, `resp_err=0`; go to IDLE.
  - Miss: increment `miss_count`, saturating at 0xFFFF; go to REQ.
- **REQ**
  - `mem_req=1`, `mem_addr=req_addr`.
  - `mem_gnt=1` at an edge: go to WAIT.
  - `mem_rvalid` is ignored in REQ.
- **WAIT**
  - `mem_rvalid=1` at an edge: latch `mem_rdata` into `fill_data`; go to FILL.
- **FILL**
  - `cache_we=1`, `cache_addr=req_addr`, `cache_wdata=fill_data` for exactly one cycle.
  - At the edge: register `resp_valid=1`, `resp_data=fill_data`; go to IDLE.
- **Idle drive values:** `cache_we=0` outside FILL; `mem_req=0` outside REQ; `mem_addr=req_addr` at all times.
- **Stray data:** `mem_rvalid` arriving in IDLE, LOOKUP or FILL is dropped.
- **Single outstanding request:** a new `fetch_valid` is not accepted until the engine is back in IDLE.
- **Reset** (any state, including mid-miss):
  - state returns to IDLE;
  - `req_addr`, `fill_data`, `resp_data` and `miss_count` are cleared to 0;
  - `resp_valid` and `resp_err` are cleared to 0.
  - A grant or read data that arrives after reset is ignored.

## Timing
- **Reset values:** `fetch_ready=1`, `resp_valid=0`, `resp_data=0`, `resp_err=0`, `cache_we=0`, `mem_req=0`, `cache_addr=fetch_addr`, `mem_addr=0`, `cache_wdata=0`, `miss_count=0`.
- **Hit latency:** request accepted at edge E0, `resp_valid` high in the cycle after E1 (2 cycles).
- **Minimum miss latency:**
  - accept at E0, miss decided at E1;
  - `mem_gnt` at E2, `mem_rvalid` at E3;
  - fill write at E4, `resp_valid` high after E4 (5 cycles).
- Each extra cycle of `mem_gnt` or `mem_rvalid` delay adds one cycle.
- **Back-to-back:** `fetch_ready` is high in the same cycle that `resp_valid` is high, so a new request may be accepted on that edge.
- **Pulse width:** `resp_valid` is high for exactly one cycle per accepted request.

## Configuration
- **Macro:** `ICACHE_REFILL_TIMEOUT_EN`.
- **When defined:**
  - An 8-bit-or-wider wait counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When the counter reaches `TIMEOUT_CYCLES`, the engine returns to IDLE with `resp_valid=1`, `resp_err=1`, `resp_data=0`.
  - No FILL occurs and the cache is unmodified.
  - Progress on the same edge as the limit (`mem_gnt` in REQ, `mem_rvalid` in WAIT) wins over the timeout.
- **When undefined:** REQ and WAIT wait indefinitely, `resp_err` is tied to 0, and `TIMEOUT_CYCLES` is unused.

## Test plan
- **Reset:** reset asserted 3 cycles → all outputs at reset values, `fetch_ready=1`, `miss_count=0`.
- **Miss then fill:** fetch 0x0000_0040 on a cold cache, `mem_gnt` one cycle after `mem_req`, `mem_rvalid` with 0xDEAD_BEEF one cycle later → `mem_addr=0x40`; one `cache_we` pulse with `cache_wdata=0xDEAD_BEEF`; `resp_data=0xDEAD_BEEF`, `resp_err=0`; `miss_count=1`; total 5 cycles.
- **Hit after fill:** re-fetch 0x40 → `resp_valid` 2 cycles after accept, `resp_data=0xDEAD_BEEF`, no `mem_req`, `miss_count` still 1.
- **Stalled bus:** `mem_gnt` held low 10 cycles → `mem_req` and `mem_addr` stable throughout; `resp_valid` stays low until the data returns.
- **Reset mid-WAIT:** reset asserted in WAIT, then `mem_rvalid` asserted → no `cache_we` and no `resp_valid`; engine in IDLE.
- **Timeout** (macro defined, `TIMEOUT_CYCLES=8`): never assert `mem_rvalid` → `resp_valid=1`, `resp_err=1`, `resp_data=0` 8 cycles after entering REQ; no `cache_we`.
